// File: rtl/othello_turn_ctrl.sv
// Turn sequencer for an Othello board: cursor movement, legality handshake, pass/commit counting.
// Optional per-turn timeout timer is built only when TURN_TIMEOUT_EN is defined.
module othello_turn_ctrl #(
    parameter int BOARD_N       = 8,
    parameter int PLAYERS       = 2,
    parameter int TICK_DIV      = 833333,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       up,
    input  logic                       down,
    input  logic                       left,
    input  logic                       right,
    input  logic                       place,
    input  logic                       pass,
    input  logic                       chk_ack,
    input  logic                       chk_legal,
    output logic [$clog2(BOARD_N)-1:0] cursor_x,
    output logic [$clog2(BOARD_N)-1:0] cursor_y,
    output logic [1:0]                 player,
    output logic                       chk_req,
    output logic                       commit,
    output logic                       draw_cursor,
    output logic [7:0]                 time_left,
    output logic                       game_over,
    output logic [2:0]                 state
);
    localparam int CW = $clog2(BOARD_N);
    localparam int NW = $clog2(BOARD_N * BOARD_N);
    localparam logic [CW-1:0] MAX_C      = CW'(BOARD_N - 1);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [NW-1:0] ONE_N      = NW'(1);
    localparam logic [NW-1:0] COMMIT_LIM = NW'(BOARD_N * BOARD_N - 4);
    localparam logic [2:0]    PASS_LIM   = 3'(PLAYERS);
    localparam logic [1:0]    LAST_P     = 2'(PLAYERS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        NEXT   = 3'd4,
        OVER   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      keys, hist_q, edges;
    logic            start_e, place_e, pass_e, up_e, down_e, left_e, right_e;
    logic [CW-1:0]   cx_q, cy_q;
    logic [1:0]      player_q;
    logic [2:0]      pass_cnt_q;
    logic [NW-1:0]   commit_cnt_q;
    logic            init_game, move_up, move_down, move_left, move_right;
    logic            pass_inc, commit_inc, timeout;

    assign keys  = {start, place, pass, up, down, left, right};
    assign edges = keys & ~hist_q;
    assign {start_e, place_e, pass_e, up_e, down_e, left_e, right_e} = edges;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // start wins in every legal state; only one SELECT event is honoured per cycle
    always_comb begin
        state_d    = state_q;
        init_game  = 1'b0;
        move_up    = 1'b0;
        move_down  = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        pass_inc   = 1'b0;
        commit_inc = 1'b0;
        if (start_e && (state_q <= OVER)) begin
            state_d   = SELECT;
            init_game = 1'b1;
        end else begin
            case (state_q)
                IDLE: ;
                SELECT: begin
                    if (place_e) begin
                        state_d = CHECK;
                    end else if (pass_e || timeout) begin
                        pass_inc = 1'b1;
                        state_d  = ((pass_cnt_q + 3'd1) == PASS_LIM) ? OVER : NEXT;
                    end else if (up_e)    move_up    = 1'b1;
                    else if (down_e)      move_down  = 1'b1;
                    else if (left_e)      move_left  = 1'b1;
                    else if (right_e)     move_right = 1'b1;
                end
                CHECK:  if (chk_ack) state_d = chk_legal ? COMMIT : SELECT;
                COMMIT: begin
                    commit_inc = 1'b1;
                    state_d    = ((commit_cnt_q + ONE_N) == COMMIT_LIM) ? OVER : NEXT;
                end
                NEXT:   state_d = SELECT;
                OVER:   ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q       <= '1;
            cx_q         <= '0;
            cy_q         <= '0;
            player_q     <= '0;
            pass_cnt_q   <= '0;
            commit_cnt_q <= '0;
        end else begin
            hist_q <= keys;
            if (init_game) begin
                cx_q         <= '0;
                cy_q         <= '0;
                player_q     <= '0;
                pass_cnt_q   <= '0;
                commit_cnt_q <= '0;
            end else begin
                if (move_up)    cy_q <= (cy_q == '0)    ? MAX_C : cy_q - ONE_C;
                if (move_down)  cy_q <= (cy_q == MAX_C) ? '0    : cy_q + ONE_C;
                if (move_left)  cx_q <= (cx_q == '0)    ? MAX_C : cx_q - ONE_C;
                if (move_right) cx_q <= (cx_q == MAX_C) ? '0    : cx_q + ONE_C;
                if (pass_inc)   pass_cnt_q <= pass_cnt_q + 3'd1;
                if (commit_inc) begin
                    commit_cnt_q <= commit_cnt_q + ONE_N;
                    pass_cnt_q   <= '0;
                end
                if (state_q == NEXT) player_q <= (player_q == LAST_P) ? 2'd0 : player_q + 2'd1;
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [7:0]    tl_q;
    logic          reload;

    // free-running prescaler; the turn budget only drains while a move is pending
    assign reload = init_game || (state_q == NEXT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= PRESC_TOP;
            tl_q    <= 8'(TIMEOUT_TICKS);
        end else if (reload) begin
            presc_q <= PRESC_TOP;
            tl_q    <= 8'(TIMEOUT_TICKS);
        end else begin
            presc_q <= (presc_q == '0) ? PRESC_TOP : presc_q - PW'(1);
            if ((presc_q == '0) && ((state_q == SELECT) || (state_q == CHECK)) && (tl_q != 8'd0))
                tl_q <= tl_q - 8'd1;
        end
    end

    assign time_left = tl_q;
    assign timeout   = (tl_q == 8'd0);
`else
    assign time_left = 8'd0;
    assign timeout   = 1'b0;
`endif

    assign cursor_x    = cx_q;
    assign cursor_y    = cy_q;
    assign player      = player_q;
    assign chk_req     = (state_q == CHECK);
    assign commit      = (state_q == COMMIT);
    assign draw_cursor = (state_q == SELECT);
    assign game_over   = (state_q == OVER);
    assign state       = state_q;

endmodule

// File: tb/tb_othello_turn_ctrl.sv
// Self-checking bench for othello_turn_ctrl: vector table through a scoreboard queue,
// plus a timed sequence on a second instance with a fast timer.
module tb_othello_turn_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start, up, down, left, right, place, pass, chk_ack, chk_legal, start_t;
    logic [2:0] cursor_x, cursor_y, state, cursor_x_t, cursor_y_t, state_t;
    logic [1:0] player, player_t;
    logic [7:0] time_left, time_left_t;
    logic chk_req, commit, draw_cursor, game_over;
    logic chk_req_t, commit_t, draw_cursor_t, game_over_t;

    othello_turn_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .up(up), .down(down), .left(left),
        .right(right), .place(place), .pass(pass), .chk_ack(chk_ack), .chk_legal(chk_legal),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .player(player), .chk_req(chk_req),
        .commit(commit), .draw_cursor(draw_cursor), .time_left(time_left),
        .game_over(game_over), .state(state)
    );

    othello_turn_ctrl #(.BOARD_N(8), .PLAYERS(2), .TICK_DIV(4), .TIMEOUT_TICKS(3)) dut_t (
        .clk(clk), .reset_n(reset_n), .start(start_t), .up(1'b0), .down(1'b0), .left(1'b0),
        .right(1'b0), .place(1'b0), .pass(1'b0), .chk_ack(1'b0), .chk_legal(1'b0),
        .cursor_x(cursor_x_t), .cursor_y(cursor_y_t), .player(player_t), .chk_req(chk_req_t),
        .commit(commit_t), .draw_cursor(draw_cursor_t), .time_left(time_left_t),
        .game_over(game_over_t), .state(state_t)
    );

`ifdef TURN_TIMEOUT_EN
    localparam bit TEN = 1'b1;
    localparam logic [7:0] TLX = 8'd30;
`else
    localparam bit TEN = 1'b0;
    localparam logic [7:0] TLX = 8'd0;
`endif

    localparam logic [2:0] IDL = 3'd0, SEL = 3'd1, CHK = 3'd2, COM = 3'd3, NXT = 3'd4, OVR = 3'd5;
    // input bits {start,place,pass,up,down,left,right,ack,legal}
    localparam logic [8:0] S = 9'h100, PL = 9'h080, PS = 9'h040, U = 9'h020, D = 9'h010;
    localparam logic [8:0] L = 9'h008, R = 9'h004, A = 9'h002, G = 9'h001, NONE = 9'h000;

    typedef struct {
        logic [8:0] in;
        logic [2:0] st;
        logic [2:0] cx;
        logic [2:0] cy;
        logic [1:0] pl;
        logic       com;
    } vec_t;

    vec_t        tbl[$];
    logic [22:0] sb[$];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic void add(logic [8:0] i, logic [2:0] s, logic [2:0] x, logic [2:0] y,
                                logic [1:0] p, logic c);
        vec_t v;
        v.in = i; v.st = s; v.cx = x; v.cy = y; v.pl = p; v.com = c;
        tbl.push_back(v);
    endfunction

    function automatic logic [22:0] exp_of(vec_t v);
        return {v.st, v.cx, v.cy, v.pl, (v.st == CHK), v.com, (v.st == SEL), (v.st == OVR), TLX};
    endfunction

    function automatic logic [22:0] actual();
        return {state, cursor_x, cursor_y, player, chk_req, commit, draw_cursor, game_over, time_left};
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic run_vec(int idx, vec_t v);
        logic [22:0] got, e;
        {start, place, pass, up, down, left, right, chk_ack, chk_legal} = v.in;
        sb.push_back(exp_of(v));
        @(posedge clk); #1;
        got = actual();
        e = sb.pop_front();
        n_chk++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL vec %0d: got %h expected %h (st,x,y,pl,req,com,cur,ovr,tl)", idx, got, e);
        end
    endtask

    initial begin
        // held keys across reset release must not produce events
        add(S | U, IDL, 0, 0, 0, 0);
        add(U,     IDL, 0, 0, 0, 0);
        add(S | U, SEL, 0, 0, 0, 0);
        add(NONE,  SEL, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            add(R,    SEL, 3'(i % 8), 0, 0, 0);
            add(NONE, SEL, 3'(i % 8), 0, 0, 0);
        end
        add(U | L, SEL, 0, 7, 0, 0);
        add(NONE,  SEL, 0, 7, 0, 0);
        add(D,     SEL, 0, 0, 0, 0);
        add(NONE,  SEL, 0, 0, 0, 0);
        add(L,     SEL, 7, 0, 0, 0);
        add(NONE,  SEL, 7, 0, 0, 0);
        // illegal move: five cycles of request, then back with nothing changed
        add(PL, CHK, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(NONE, CHK, 7, 0, 0, 0);
        add(A,    SEL, 7, 0, 0, 0);
        add(NONE, SEL, 7, 0, 0, 0);
        // legal move
        add(PL,    CHK, 7, 0, 0, 0);
        add(A | G, COM, 7, 0, 0, 1);
        add(NONE,  NXT, 7, 0, 0, 0);
        add(NONE,  SEL, 7, 0, 1, 0);
        // two passes in a row end the game
        add(PS,   NXT, 7, 0, 1, 0);
        add(NONE, SEL, 7, 0, 0, 0);
        add(PS,   OVR, 7, 0, 0, 0);
        add(NONE, OVR, 7, 0, 0, 0);
        add(S,    SEL, 0, 0, 0, 0);
        add(NONE, SEL, 0, 0, 0, 0);
        // priorities and restart from CHECK
        add(PL | PS | R, CHK, 0, 0, 0, 0);
        add(S,           SEL, 0, 0, 0, 0);
        add(NONE,        SEL, 0, 0, 0, 0);
        add(PS | U,      NXT, 0, 0, 0, 0);
        add(NONE,        SEL, 0, 0, 1, 0);
        add(S | PL,      SEL, 0, 0, 0, 0);
        add(NONE,        SEL, 0, 0, 0, 0);
        add(U | D,       SEL, 0, 7, 0, 0);
        add(NONE,        SEL, 0, 7, 0, 0);

        reset_n = 1'b0; start_t = 1'b0;
        {start, place, pass, up, down, left, right, chk_ack, chk_legal} = S | U;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(actual()), 32'({IDL, 3'd0, 3'd0, 2'd0, 4'b0000, TLX}));
        chk("reset_t_time_left", 32'(time_left_t), TEN ? 32'd3 : 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // timeout on the fast-timer instance
        start_t = 1'b1;
        @(posedge clk); #1;
        start_t = 1'b0;
        chk("t_enter_state", 32'(state_t), 32'(SEL));
        chk("t_enter_tl", 32'(time_left_t), TEN ? 32'd3 : 32'd0);
        repeat (11) @(posedge clk);
        #1;
        chk("t_k11_tl", 32'(time_left_t), TEN ? 32'd1 : 32'd0);
        chk("t_k11_state", 32'(state_t), 32'(SEL));
        @(posedge clk); #1;
        chk("t_k12_tl", 32'(time_left_t), 32'd0);
        chk("t_k12_state", 32'(state_t), 32'(SEL));
        @(posedge clk); #1;
        chk("t_k13_state", 32'(state_t), TEN ? 32'(NXT) : 32'(SEL));
        @(posedge clk); #1;
        chk("t_k14_state", 32'(state_t), 32'(SEL));
        chk("t_k14_player", 32'(player_t), TEN ? 32'd1 : 32'd0);
        chk("t_k14_tl", 32'(time_left_t), TEN ? 32'd3 : 32'd0);
        if (!TEN) begin
            repeat (40) @(posedge clk);
            #1;
            chk("t_never_state", 32'(state_t), 32'(SEL));
            chk("t_never_player", 32'(player_t), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
